// File: rtl/hdlc_tx_sequencer.sv
// hdlc_tx_sequencer: serial side of the HDLC transmitter (flags, zero-stuffed payload, abort, idle).
// Build option HDLC_TX_FCS_EN appends a CRC-16 FCS field between payload and end flag.
module hdlc_tx_sequencer #(
    parameter int MAX_FRAME_BYTES = 126,
    parameter int FLAG_GAP        = 0
) (
    input  logic       Clk_i,
    input  logic       Rst_i,
    input  logic       Tx_Enable_i,
    input  logic [7:0] Tx_FrameSize_i,
    input  logic       Tx_AbortFrame_i,
    input  logic [7:0] Tx_DataOutBuff_i,
    output logic       Tx_RdBuff_o,
    output logic       Tx_o,
    output logic       Tx_ValidFrame_o,
    output logic       Tx_Done_o,
    output logic       Tx_AbortedTrans_o
);

    // state   | meaning
    // S_IDLE  | line idle (1s), waiting for Tx_Enable
    // S_START | shifting opening flag 0x7E
    // S_DATA  | shifting payload bytes with zero insertion
    // S_FCS   | shifting CRC-16, low byte first (HDLC_TX_FCS_EN only)
    // S_END   | shifting closing flag 0x7E
    // S_ABORT | shifting abort pattern 0 then seven 1s
    // S_GAP   | enforced idle 1s before the next frame
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_FCS,
        S_END,
        S_ABORT,
        S_GAP
    } state_t;

    localparam logic [7:0] FLAG    = 8'h7E;
    localparam logic [7:0] MAX_LEN = 8'(MAX_FRAME_BYTES);

    state_t      state_q, state_d;
    logic        tx_q, tx_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  ones_q, ones_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        rd_q, rd_d;
    logic        pend_q, pend_d;
    logic [7:0]  rem_q, rem_d;
    logic        done_q, done_d;
    logic        abrt_q, abrt_d;
    logic [15:0] gap_q, gap_d;

    logic [2:0]  nxt3;
    logic        dbit;
    logic        emit;
    logic        go_abort;

`ifdef HDLC_TX_FCS_EN
    logic [15:0] crc_q, crc_d;

    function automatic logic [15:0] crc_next(input logic [15:0] c, input logic b);
        return (c >> 1) ^ (((c[0] ^ b) == 1'b1) ? 16'h8408 : 16'h0000);
    endfunction
`endif

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        bit_cnt_d  = bit_cnt_q;
        ones_d     = ones_q;
        sh_d       = sh_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        rd_d       = 1'b0;
        pend_d     = rd_q;
        rem_d      = rem_q;
        done_d     = done_q;
        abrt_d     = abrt_q;
        gap_d      = gap_q;
`ifdef HDLC_TX_FCS_EN
        crc_d      = crc_q;
`endif
        nxt3       = bit_cnt_q[2:0] + 3'd1;
        dbit       = 1'b0;
        emit       = 1'b0;
        go_abort   = Tx_AbortFrame_i &&
                     (state_q == S_START || state_q == S_DATA || state_q == S_FCS);

        if (pend_q) begin
            hold_d     = Tx_DataOutBuff_i;
            hold_vld_d = 1'b1;
        end
        if (rd_q && rem_q == 8'd0) begin
            done_d = 1'b1;
        end

        if (go_abort) begin
            state_d    = S_ABORT;
            tx_d       = 1'b0;
            bit_cnt_d  = 4'd0;
            ones_d     = 3'd0;
            done_d     = 1'b1;
            abrt_d     = 1'b1;
            rem_d      = 8'd0;
            hold_vld_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_d = 1'b1;
                    if (Tx_Enable_i && Tx_FrameSize_i != 8'd0) begin
                        state_d    = S_START;
                        tx_d       = FLAG[0];
                        bit_cnt_d  = 4'd0;
                        ones_d     = 3'd0;
                        done_d     = 1'b0;
                        abrt_d     = 1'b0;
                        hold_vld_d = 1'b0;
                        rem_d      = (Tx_FrameSize_i > MAX_LEN) ? MAX_LEN : Tx_FrameSize_i;
`ifdef HDLC_TX_FCS_EN
                        crc_d      = 16'h0000;
`endif
                    end
                end
                S_START: begin
                    if (bit_cnt_q != 4'd7) begin
                        tx_d      = FLAG[nxt3];
                        bit_cnt_d = {1'b0, nxt3};
                    end else begin
                        state_d    = S_DATA;
                        sh_d       = hold_q;
                        hold_vld_d = 1'b0;
                        bit_cnt_d  = 4'd0;
                        dbit       = hold_q[0];
                        emit       = 1'b1;
                    end
                end
                S_DATA: begin
                    // stuffed zero keeps bit_cnt, so the next data bit is still bit_cnt+1
                    if (ones_q == 3'd5) begin
                        tx_d   = 1'b0;
                        ones_d = 3'd0;
                    end else if (bit_cnt_q != 4'd7) begin
                        dbit      = sh_q[nxt3];
                        emit      = 1'b1;
                        bit_cnt_d = {1'b0, nxt3};
                    end else if (hold_vld_q) begin
                        sh_d       = hold_q;
                        hold_vld_d = 1'b0;
                        bit_cnt_d  = 4'd0;
                        dbit       = hold_q[0];
                        emit       = 1'b1;
                    end else begin
`ifdef HDLC_TX_FCS_EN
                        state_d   = S_FCS;
                        bit_cnt_d = 4'd0;
                        tx_d      = crc_q[0];
                        ones_d    = crc_q[0] ? 3'(ones_q + 3'd1) : 3'd0;
                        crc_d     = crc_q >> 1;
`else
                        state_d   = S_END;
                        bit_cnt_d = 4'd0;
                        tx_d      = FLAG[0];
                        ones_d    = 3'd0;
`endif
                    end
                end
`ifdef HDLC_TX_FCS_EN
                S_FCS: begin
                    if (ones_q == 3'd5) begin
                        tx_d   = 1'b0;
                        ones_d = 3'd0;
                    end else if (bit_cnt_q != 4'd15) begin
                        tx_d      = crc_q[0];
                        ones_d    = crc_q[0] ? 3'(ones_q + 3'd1) : 3'd0;
                        crc_d     = crc_q >> 1;
                        bit_cnt_d = 4'(bit_cnt_q + 4'd1);
                    end else begin
                        state_d   = S_END;
                        bit_cnt_d = 4'd0;
                        tx_d      = FLAG[0];
                        ones_d    = 3'd0;
                    end
                end
`endif
                S_END, S_ABORT: begin
                    if (bit_cnt_q != 4'd7) begin
                        tx_d      = (state_q == S_END) ? FLAG[nxt3] : 1'b1;
                        bit_cnt_d = {1'b0, nxt3};
                    end else begin
                        tx_d      = 1'b1;
                        bit_cnt_d = 4'd0;
                        if (FLAG_GAP == 0) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = 16'(FLAG_GAP - 1);
                        end
                    end
                end
                S_GAP: begin
                    tx_d = 1'b1;
                    if (gap_q == 16'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d = gap_q - 16'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end

        if (emit) begin
            tx_d   = dbit;
            ones_d = dbit ? 3'(ones_q + 3'd1) : 3'd0;
`ifdef HDLC_TX_FCS_EN
            crc_d  = crc_next(crc_q, dbit);
`endif
        end

        // one outstanding fetch at a time; remaining counts strobes still to issue
        if ((state_q == S_START || state_q == S_DATA) && !go_abort && !hold_vld_q &&
            !rd_q && !pend_q && rem_q != 8'd0) begin
            rd_d  = 1'b1;
            rem_d = rem_q - 8'd1;
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            bit_cnt_q  <= 4'd0;
            ones_q     <= 3'd0;
            sh_q       <= 8'd0;
            hold_q     <= 8'd0;
            hold_vld_q <= 1'b0;
            rd_q       <= 1'b0;
            pend_q     <= 1'b0;
            rem_q      <= 8'd0;
            done_q     <= 1'b1;
            abrt_q     <= 1'b0;
            gap_q      <= 16'd0;
`ifdef HDLC_TX_FCS_EN
            crc_q      <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_q     <= ones_d;
            sh_q       <= sh_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            rd_q       <= rd_d;
            pend_q     <= pend_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            abrt_q     <= abrt_d;
            gap_q      <= gap_d;
`ifdef HDLC_TX_FCS_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign Tx_o              = tx_q;
    assign Tx_RdBuff_o       = rd_q;
    assign Tx_Done_o         = done_q;
    assign Tx_AbortedTrans_o = abrt_q;
    assign Tx_ValidFrame_o   = (state_q == S_START) || (state_q == S_DATA) ||
                               (state_q == S_FCS)   || (state_q == S_END);

endmodule

// File: tb/tb_hdlc_tx_sequencer.sv
// Directed bench for hdlc_tx_sequencer: idle vector table plus frame, stuffing, abort and reset sequences.
module tb_hdlc_tx_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en = 1'b0;
    logic       abrt = 1'b0;
    logic [7:0] fsize = 8'd0;
    logic [7:0] buf_data = 8'd0;
    logic       rd, tx, valid, done, aborted;

    int n_chk = 0;
    int n_fail = 0;
    int rd_count = 0;
    int base = 0;
    logic [7:0] buf_mem [0:255];
    bit exp_q[$];
    bit got_q[$];

    typedef struct {
        logic       en;
        logic [7:0] size;
        logic       ab;
        int         cycles;
        logic       e_tx;
        logic       e_valid;
        logic       e_done;
    } vec_t;
    vec_t vt[5];

    always #5 clk = ~clk;

    hdlc_tx_sequencer #(.MAX_FRAME_BYTES(126), .FLAG_GAP(0)) dut (
        .Clk_i            (clk),
        .Rst_i            (rst_n),
        .Tx_Enable_i      (tx_en),
        .Tx_FrameSize_i   (fsize),
        .Tx_AbortFrame_i  (abrt),
        .Tx_DataOutBuff_i (buf_data),
        .Tx_RdBuff_o      (rd),
        .Tx_o             (tx),
        .Tx_ValidFrame_o  (valid),
        .Tx_Done_o        (done),
        .Tx_AbortedTrans_o(aborted)
    );

    // buffer model: data valid the cycle after the strobe
    always @(posedge clk) begin
        if (rd) begin
            buf_data <= buf_mem[8'(rd_count - base)];
            rd_count <= rd_count + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_data(input bit b, inout int ones);
        exp_q.push_back(b);
        ones = b ? ones + 1 : 0;
        if (ones == 5) begin
            exp_q.push_back(1'b0);
            ones = 0;
        end
    endtask

    task automatic build_exp(input int n);
        int ones;
        logic [7:0] f;
        logic [15:0] crc;
        ones = 0;
        f = 8'h7E;
        crc = 16'h0000;
        exp_q.delete();
        for (int b = 0; b < 8; b++) exp_q.push_back(f[b]);
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) push_data(buf_mem[i][b], ones);
            crc = crc ^ {8'h00, buf_mem[i]};
            for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 16'h8408) : (crc >> 1);
        end
`ifdef HDLC_TX_FCS_EN
        for (int b = 0; b < 16; b++) push_data(crc[b], ones);
`endif
        for (int b = 0; b < 8; b++) exp_q.push_back(f[b]);
    endtask

    task automatic run_frame(input int sz, input bit with_abort, input string tag);
        int n, mism, vcnt, rd0;
        n = (sz > 126) ? 126 : sz;
        build_exp(n);
        got_q.delete();
        @(negedge clk);
        base = rd_count;
        rd0 = rd_count;
        tx_en = 1'b1;
        fsize = 8'(sz);
        abrt = with_abort;
        @(negedge clk);
        tx_en = 1'b0;
        abrt = 1'b0;
        chk({tag, "_aborted_clear"}, int'(aborted), 0);
        chk({tag, "_done_low"}, int'(done), 0);
        mism = 0;
        vcnt = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            got_q.push_back(tx);
            if (tx !== exp_q[i]) mism++;
            if (valid === 1'b1) vcnt++;
            tx_en = (i == 10);
            @(negedge clk);
        end
        tx_en = 1'b0;
        chk({tag, "_bit_mismatches"}, mism, 0);
        chk({tag, "_valid_cycles"}, vcnt, exp_q.size());
        chk({tag, "_valid_after"}, int'(valid), 0);
        chk({tag, "_tx_after"}, int'(tx), 1);
        chk({tag, "_rd_pulses"}, rd_count - rd0, n);
        chk({tag, "_done_end"}, int'(done), 1);
    endtask

    initial begin
        int bad_tx, bad_v, bad_d, rd0, mism, ones, idle1;
        logic [17:0] pat3;
        logic [15:0] pat2;

        vt[0] = '{1'b0, 8'd0,  1'b0, 20, 1'b1, 1'b0, 1'b1};
        vt[1] = '{1'b0, 8'd5,  1'b1, 4,  1'b1, 1'b0, 1'b1};
        vt[2] = '{1'b1, 8'd0,  1'b0, 4,  1'b1, 1'b0, 1'b1};
        vt[3] = '{1'b1, 8'd0,  1'b1, 3,  1'b1, 1'b0, 1'b1};
        vt[4] = '{1'b0, 8'd9,  1'b0, 3,  1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_tx", int'(tx), 1);
        chk("reset_done", int'(done), 1);
        chk("reset_valid", int'(valid), 0);
        chk("reset_aborted", int'(aborted), 0);
        rst_n = 1'b1;

        // idle behaviour table
        rd0 = rd_count;
        for (int v = 0; v < 5; v++) begin
            tx_en = vt[v].en;
            fsize = vt[v].size;
            abrt = vt[v].ab;
            bad_tx = 0;
            bad_v = 0;
            bad_d = 0;
            for (int c = 0; c < vt[v].cycles; c++) begin
                @(negedge clk);
                if (tx !== vt[v].e_tx) bad_tx++;
                if (valid !== vt[v].e_valid) bad_v++;
                if (done !== vt[v].e_done) bad_d++;
            end
            chk($sformatf("idle_vec%0d_tx", v), bad_tx, 0);
            chk($sformatf("idle_vec%0d_valid", v), bad_v, 0);
            chk($sformatf("idle_vec%0d_done", v), bad_d, 0);
        end
        tx_en = 1'b0;
        abrt = 1'b0;
        fsize = 8'd0;
        chk("idle_rd_pulses", rd_count - rd0, 0);

        // two-byte frame
        buf_mem[0] = 8'h01;
        buf_mem[1] = 8'h80;
        run_frame(2, 1'b0, "two_byte");
        pat2 = 16'b1000_0000_0000_0001;
        mism = 0;
        for (int k = 0; k < 16; k++) if (got_q[8 + k] != pat2[15 - k]) mism++;
        chk("two_byte_payload_bits", mism, 0);

        // stuffing across a byte boundary
        buf_mem[0] = 8'hFF;
        buf_mem[1] = 8'h1F;
        run_frame(2, 1'b0, "stuff");
        pat3 = 18'b111110111110111000;
        mism = 0;
        for (int k = 0; k < 18; k++) if (got_q[8 + k] != pat3[17 - k]) mism++;
        chk("stuff_payload_bits", mism, 0);

        // abort in the middle of the third byte
        for (int i = 0; i < 10; i++) buf_mem[i] = 8'h55;
        @(negedge clk);
        base = rd_count;
        tx_en = 1'b1;
        fsize = 8'd10;
        @(negedge clk);
        tx_en = 1'b0;
        for (int i = 0; i < 28; i++) @(negedge clk);
        abrt = 1'b1;
        @(negedge clk);
        abrt = 1'b0;
        chk("abort_first_bit", int'(tx), 0);
        chk("abort_valid", int'(valid), 0);
        chk("abort_sticky", int'(aborted), 1);
        chk("abort_done", int'(done), 1);
        rd0 = rd_count;
        ones = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (tx === 1'b1 && valid === 1'b0) ones++;
        end
        chk("abort_ones", ones, 7);
        idle1 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (tx === 1'b1 && valid === 1'b0 && aborted === 1'b1) idle1++;
        end
        chk("abort_idle", idle1, 6);
        chk("abort_no_more_rd", rd_count - rd0, 0);

        // enable with a simultaneous abort in idle: start wins, sticky flag clears
        run_frame(3, 1'b1, "restart");

        // oversize frame clamps to 126 bytes
        for (int i = 0; i < 256; i++) buf_mem[i] = 8'((i * 37) ^ 8'h5A);
        run_frame(200, 1'b0, "clamp");

        // size zero starts nothing
        rd0 = rd_count;
        tx_en = 1'b1;
        fsize = 8'd0;
        bad_v = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid !== 1'b0 || tx !== 1'b1) bad_v++;
        end
        tx_en = 1'b0;
        chk("size0_no_frame", bad_v, 0);
        chk("size0_no_rd", rd_count - rd0, 0);

        // asynchronous reset during payload
        buf_mem[0] = 8'h00;
        buf_mem[1] = 8'h00;
        buf_mem[2] = 8'h00;
        buf_mem[3] = 8'h00;
        @(negedge clk);
        base = rd_count;
        tx_en = 1'b1;
        fsize = 8'd4;
        @(negedge clk);
        tx_en = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_pre_valid", int'(valid), 1);
        chk("rst_pre_tx", int'(tx), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_tx", int'(tx), 1);
        chk("rst_async_valid", int'(valid), 0);
        chk("rst_async_done", int'(done), 1);
        chk("rst_async_rd", int'(rd), 0);
        chk("rst_async_aborted", int'(aborted), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad_tx = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || valid !== 1'b0) bad_tx++;
        end
        chk("rst_release_idle", bad_tx, 0);

        buf_mem[0] = 8'hA5;
        run_frame(1, 1'b0, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
